// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
// Holds the mul/div op codes and the sequencer state encoding.
package muldiv_seq_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_RUN  = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the sequencer: radix-2 shift-add for multiply,
// restoring subtract-and-shift for divide. acc holds {upper, lower} halves.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 is_div,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   acc_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : '0)};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, operand};
    // diff[WIDTH] is the borrow: remainder stays below 2*divisor, so it is exact
    if (is_div) begin
      if (!diff[WIDTH]) acc_next = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else              acc_next = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_next = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO. Operates on magnitudes,
// applies signs in the FIX cycle, and stalls decode while a result is pending.
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_x,
  input  logic [WIDTH-1:0] op_y,
  input  logic             kill,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_t          state;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   operand;
  logic               is_div, neg_res, neg_rem, div_zero;

  logic               is_signed, x_neg, y_neg;
  logic [WIDTH-1:0]   x_abs, y_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;

  always_comb begin
    is_signed = (op == MD_MULT) || (op == MD_DIV);
    x_neg     = is_signed & op_x[WIDTH-1];
    y_neg     = is_signed & op_y[WIDTH-1];
    x_abs     = x_neg ? -op_x : op_x;
    y_abs     = y_neg ? -op_y : op_y;
    prod_fix  = neg_res ? -acc : acc;
    // divide by zero leaves |x| as remainder, so the sign fix restores op_x in hi
    quot_fix  = div_zero ? '1 : (neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div   (is_div),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MD_IDLE;
      count    <= '0;
      acc      <= '0;
      operand  <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start && !kill) begin
            state    <= MD_RUN;
            count    <= CW'(WIDTH - 1);
            is_div   <= op[1];
            neg_res  <= x_neg ^ y_neg;
            neg_rem  <= x_neg;
            div_zero <= op[1] && (op_y == '0);
            if (op[1]) begin
              acc     <= {{WIDTH{1'b0}}, x_abs};
              operand <= y_abs;
            end else begin
              acc     <= {{WIDTH{1'b0}}, y_abs};
              operand <= x_abs;
            end
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        MD_RUN: begin
          if (kill) begin
            state <= MD_IDLE;
          end else begin
            acc <= acc_next;
            if (count == '0) state <= MD_FIX;
            else             count <= count - 1'b1;
          end
        end
        MD_FIX: begin
          state <= MD_IDLE;
          if (!kill) begin
            if (is_div) begin
              hi <= rem_fix;
              lo <= quot_fix;
            end else begin
              {hi, lo} <= prod_fix;
            end
          end
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign busy  = (state != MD_IDLE);
  assign stall = busy & (rd_hilo | start | mthi | mtlo);
  assign done  = (state == MD_FIX) & ~kill;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: expected HI/LO pairs are queued at issue
// and popped when the sequencer finishes; protocol checks are done inline.
module tb_muldiv_seq;
  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, kill, mthi, mtlo, rd_hilo;
  logic [1:0]   op;
  logic [W-1:0] op_x, op_y, wdata;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_x(op_x), .op_y(op_y),
    .kill(kill), .mthi(mthi), .mtlo(mtlo), .wdata(wdata), .rd_hilo(rd_hilo),
    .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x,
                                        input logic [31:0] y);
    logic signed [63:0] sx, sy;
    logic signed [31:0] qs, rs;
    case (o)
      2'b00: begin
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        return sx * sy;
      end
      2'b01: return {32'h0, x} * {32'h0, y};
      2'b10: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        qs = $signed(x) / $signed(y);
        rs = $signed(x) % $signed(y);
        return {rs, qs};
      end
      default: begin
        if (y == 32'h0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [63:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_q.push_back(model(o, x, y));
    op = o; op_x = x; op_y = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output bit seen);
    cyc = 0; seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy) cyc++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({busy, stall, done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, stall, done});
    end
    n_tests++;
    if ({hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mthi_mtlo();
    // kill in IDLE must not block the moves
    mthi = 1'b1; mtlo = 1'b1; kill = 1'b1; wdata = 32'hA5A5_0F0F;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0; kill = 1'b0;
    n_tests++;
    if ({hi, lo} !== 64'hA5A5_0F0F_A5A5_0F0F) begin
      n_fail++; $display("FAIL mthi_mtlo_both: got %h expected a5a50f0fa5a50f0f", {hi, lo});
    end
    mthi = 1'b1; wdata = 32'h0000_1111;
    @(negedge clk);
    mthi = 1'b0;
    n_tests++;
    if ({hi, lo} !== 64'h0000_1111_A5A5_0F0F) begin
      n_fail++; $display("FAIL mthi_only: got %h expected 00001111a5a50f0f", {hi, lo});
    end
  endtask

  task automatic test_multu_max();
    int cyc; bit seen; logic [63:0] e;
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(cyc, seen);
    n_tests++;
    if (!seen || cyc != 33) begin
      n_fail++; $display("FAIL multu_latency: got busy=%0d done_seen=%0d expected 33 1", cyc, seen);
    end
    @(negedge clk);
    n_tests++;
    if ({done, busy} !== 2'b00) begin
      n_fail++; $display("FAIL multu_done_width: got done,busy=%b expected 00", {done, busy});
    end
    e = pop_exp();
    n_tests++;
    if ({hi, lo} !== e || e !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++; $display("FAIL multu_result: got %h expected fffffffe00000001", {hi, lo});
    end
  endtask

  task automatic test_signed_div();
    logic [1:0]  t_op [7] = '{2'b00, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
    logic [31:0] t_x  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd100, 32'h8000_0000,
                              32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF};
    logic [31:0] t_y  [7] = '{32'd7, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'd0,
                              32'hFFFF_FFFE, 32'd3};
    int cyc; bit seen; logic [63:0] e;
    for (int i = 0; i < 7; i++) begin
      issue(t_op[i], t_x[i], t_y[i]);
      wait_done(cyc, seen);
      @(negedge clk);
      e = pop_exp();
      n_tests++;
      if (!seen || {hi, lo} !== e) begin
        n_fail++;
        $display("FAIL signed_case%0d: got hi=%h lo=%h done_seen=%0d expected hi=%h lo=%h",
                 i, hi, lo, seen, e[63:32], e[31:0]);
      end
    end
  endtask

  task automatic test_stall();
    int cnt; bit seen; logic [63:0] e;
    cnt = 0; seen = 1'b0;
    issue(2'b00, 32'h0001_2345, 32'hFFFF_6789);
    @(negedge clk);
    // MFHI reaches ID one cycle after the op began: 32 of the 33 busy cycles
    rd_hilo = 1'b1;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (stall) cnt++;
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    n_tests++;
    if (!seen || cnt != 32) begin
      n_fail++; $display("FAIL stall_cycles: got %0d done_seen=%0d expected 32 1", cnt, seen);
    end
    @(negedge clk);
    n_tests++;
    if (stall !== 1'b0) begin
      n_fail++; $display("FAIL stall_release: got %b expected 0", stall);
    end
    e = pop_exp();
    n_tests++;
    if ({hi, lo} !== e) begin
      n_fail++; $display("FAIL stall_result: got %h expected %h", {hi, lo}, e);
    end
    rd_hilo = 1'b0;
  endtask

  task automatic test_start_held();
    int cyc; bit seen; logic [63:0] e;
    issue(2'b11, 32'd1000, 32'd7);
    repeat (5) @(negedge clk);
    exp_q.push_back(model(2'b01, 32'd12345, 32'd6789));
    op = 2'b01; op_x = 32'd12345; op_y = 32'd6789; start = 1'b1;
    #1;
    n_tests++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL held_start_stall: got %b expected 1", stall);
    end
    wait_done(cyc, seen);
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if (!seen || {hi, lo} !== e) begin
      n_fail++; $display("FAIL held_first_result: got %h expected %h", {hi, lo}, e);
    end
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, seen);
    n_tests++;
    if (!seen || cyc != 33) begin
      n_fail++; $display("FAIL held_second_latency: got %0d expected 33", cyc);
    end
    @(negedge clk);
    e = pop_exp();
    n_tests++;
    if ({hi, lo} !== e) begin
      n_fail++; $display("FAIL held_second_result: got %h expected %h", {hi, lo}, e);
    end
  endtask

  task automatic test_kill();
    bit done_seen;
    done_seen = 1'b0;
    mthi = 1'b1; wdata = 32'h0000_1234;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_5678;
    @(negedge clk);
    mtlo = 1'b0;
    op = 2'b10; op_x = 32'd1000; op_y = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL kill_idle: got busy=%b expected 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) done_seen = 1'b1;
      @(negedge clk);
    end
    n_tests++;
    if (done_seen || {hi, lo} !== 64'h0000_1234_0000_5678) begin
      n_fail++;
      $display("FAIL kill_hilo: got hi=%h lo=%h done_seen=%0d expected hi=00001234 lo=00005678 0",
               hi, lo, done_seen);
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit seen; logic [63:0] e;
    logic [1:0] o; logic [31:0] x, y;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i % 4);
      x = $urandom;
      y = (i == 6) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 1000));
      issue(o, x, y);
      wait_done(cyc, seen);
      @(negedge clk);
      e = pop_exp();
      n_tests++;
      if (!seen || cyc != 33 || {hi, lo} !== e) begin
        n_fail++;
        $display("FAIL b2b_op%0d: got busy=%0d hi=%h lo=%h expected 33 hi=%h lo=%h (op=%0d x=%h y=%h)",
                 i, cyc, hi, lo, e[63:32], e[31:0], o, x, y);
      end
    end
  endtask

  task automatic test_async_reset();
    mtlo = 1'b1; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mtlo = 1'b0;
    op = 2'b01; op_x = 32'd3; op_y = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0; rd_hilo = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, stall, done} !== 3'b000 || {hi, lo} !== 64'h0) begin
      n_fail++; $display("FAIL async_reset: got flags=%b hilo=%h expected 000 0",
                         {busy, stall, done}, {hi, lo});
    end
    @(negedge clk);
    rst = 1'b0; rd_hilo = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; kill = 1'b0; mthi = 1'b0; mtlo = 1'b0; rd_hilo = 1'b0;
    op = '0; op_x = '0; op_y = '0; wdata = '0;
    test_reset();
    test_mthi_mtlo();
    test_multu_max();
    test_signed_div();
    test_stall();
    test_start_held();
    test_kill();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
